// File: rtl/bin_compress_pkg.sv
// Shared log-scale widths, clear/run state encoding and saturating subtract for bin_compress.
// Latency: none (types and functions only).
// Backpressure: n/a.
package bin_compress_pkg;

    localparam int LOG_EXP_W = 4;
    localparam int LOG_MAN_W = 4;
    localparam int LOG_W     = LOG_EXP_W + LOG_MAN_W;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    function automatic logic [LOG_W-1:0] sat_sub(input logic [LOG_W-1:0] a,
                                                  input logic [LOG_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/bin_compress_lzc_log16.sv
// MSB detect plus 4-bit mantissa extract: log_val = {msb index, next 4 bits left-aligned}.
// Latency: combinational.
// Backpressure: n/a.
module lzc_log16
    import bin_compress_pkg::*;
(
    input  logic [15:0]      din,
    output logic [LOG_W-1:0] log_val,
    output logic             zero
);

    logic [LOG_EXP_W-1:0] p;
    logic [15:0]          norm;

    always_comb begin
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if (din[i]) p = LOG_EXP_W'(i);
        end
        // Shift the MSB up to bit 15; the mantissa is whatever lands just below it,
        // which zero-pads naturally for small magnitudes.
        norm    = din << (4'd15 - p);
        zero    = (din == 16'd0);
        log_val = {p, norm[14 -: LOG_MAN_W]};
    end

endmodule

// File: rtl/bin_compress.sv
// Bin magnitude -> 8-bit log intensity with noise floor; peak-hold/decay when BIN_COMPRESS_PEAK_HOLD_EN is defined.
// Latency: fixed 3 cycles, one input per cycle.
// Backpressure: in_ready low during the post-reset hold-memory clear sweep; inputs offered then are dropped.
module bin_compress
    import bin_compress_pkg::*;
#(
    parameter int               FREQ_BINS   = 320,
    parameter int               ADDR_W      = 9,
    parameter int               IN_W        = 16,
    parameter logic [LOG_W-1:0] NOISE_FLOOR = 8'd32,
    parameter logic [LOG_W-1:0] DECAY       = 8'd2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [LOG_W-1:0]  out_data
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FREQ_BINS - 1);

    logic              accept;
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_addr;
    logic [IN_W-1:0]   s1_dat;
    logic              s2_vld;
    logic [ADDR_W-1:0] s2_addr;
    logic [LOG_W-1:0]  s2_log;
    logic [LOG_W-1:0]  lzc_log;
    logic              lzc_zero;
    logic [LOG_W-1:0]  floor_log;
    logic [LOG_W-1:0]  h_val;
    logic [LOG_W-1:0]  d_val;
    logic [LOG_W-1:0]  r_val;
    logic              in_range;

    assign accept = in_valid && in_ready;

    lzc_log16 u_lzc (
        .din     (s1_dat),
        .log_val (lzc_log),
        .zero    (lzc_zero)
    );

    assign floor_log = lzc_zero ? '0 : sat_sub(lzc_log, NOISE_FLOOR);
    assign in_range  = (s2_addr <= LAST_BIN);
    assign d_val     = sat_sub(h_val, DECAY);
    // Out-of-range bins have no hold entry, so they pass the floored log straight through.
    assign r_val     = (in_range && (d_val > s2_log)) ? d_val : s2_log;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s1_addr   <= '0;
            s1_dat    <= '0;
            s2_vld    <= 1'b0;
            s2_addr   <= '0;
            s2_log    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            s1_vld    <= accept;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (accept) begin
                s1_addr <= in_addr;
                s1_dat  <= in_data;
            end
            if (s1_vld) begin
                s2_addr <= s1_addr;
                s2_log  <= floor_log;
            end
            if (s2_vld) begin
                out_addr <= s2_addr;
                out_data <= r_val;
            end
        end
    end

`ifdef BIN_COMPRESS_PEAK_HOLD_EN
    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [LOG_W-1:0]  hold_mem [FREQ_BINS];
    logic [LOG_W-1:0]  hold_rd;
    logic              hold_we;
    logic [ADDR_W-1:0] hold_wa;
    logic [LOG_W-1:0]  hold_wd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            in_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_BIN) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_RUN:  in_ready <= 1'b1;
                default: state    <= ST_CLEAR;
            endcase
        end
    end

    always_comb begin
        hold_we = (state == ST_CLEAR) || (s2_vld && in_range);
        hold_wa = (state == ST_CLEAR) ? clr_cnt : s2_addr;
        hold_wd = (state == ST_CLEAR) ? '0 : r_val;
    end

    // Array carries no reset; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (hold_we) hold_mem[hold_wa] <= hold_wd;
        hold_rd <= hold_mem[s1_addr];
    end

    // The read for the entry now in S3 raced the write of the one just ahead of it;
    // anything older already landed in the array before the read.
    assign h_val = (out_valid && (out_addr == s2_addr)) ? out_data : hold_rd;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) in_ready <= 1'b0;
        else       in_ready <= 1'b1;
    end

    assign h_val = '0;
`endif

endmodule

// File: tb/tb_bin_compress.sv
// Self-checking bench: two instances (noise floor 0 and default 32) share stimulus and are
// compared against a queue-based reference model plus constant vectors.
module tb_bin_compress;

    localparam int NB = 320;
`ifdef BIN_COMPRESS_PEAK_HOLD_EN
    localparam bit HOLD = 1'b1;
    localparam int RDY  = NB;
`else
    localparam bit HOLD = 1'b0;
    localparam int RDY  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [8:0]  in_addr = '0;
    logic [15:0] in_data = '0;

    logic       rdy0, ov0, rdy1, ov1;
    logic [8:0] oa0, oa1;
    logic [7:0] od0, od1;

    always #5 clk = ~clk;

    bin_compress #(.NOISE_FLOOR(8'd0)) u_nf0 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_addr(in_addr), .in_data(in_data),
        .out_valid(ov0), .out_addr(oa0), .out_data(od0)
    );

    bin_compress u_nfd (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_addr(in_addr), .in_data(in_data),
        .out_valid(ov1), .out_addr(oa1), .out_data(od1)
    );

    typedef struct {
        int due;
        int addr;
        int e0;
        int e1;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    exp_t q[$];
    vec_t tbl[8];
    int   hold0[NB];
    int   hold1[NB];
    int   cyc = 0;
    int   k = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   has_exp = 1'b0;
    int   exp0 = 0;
    int   exp1 = 0;

    function automatic int ref_log(int x);
        int p;
        if (x == 0) return 0;
        p = 0;
        while ((x >> (p + 1)) != 0) p++;
        return p * 16 + (((x * 16) >> p) & 15);
    endfunction

    function automatic int ref_sub(int a, int b);
        return (a > b) ? a - b : 0;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(string nm, int act, int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, want);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) k = 0;
        else     k = k + 1;
    end

    // Monitor and reference model: sample away from the active edge.
    always @(negedge clk) begin
        int   lp0, lp1, r0, r1;
        bit   ev, rdy_exp;
        exp_t e;
        if (rst) begin
            chk("rst_vld0", ov0, 0);  chk("rst_vld1", ov1, 0);
            chk("rst_addr0", oa0, 0); chk("rst_addr1", oa1, 0);
            chk("rst_data0", od0, 0); chk("rst_data1", od1, 0);
            chk("rst_rdy0", rdy0, 0); chk("rst_rdy1", rdy1, 0);
            q.delete();
            for (int i = 0; i < NB; i++) begin
                hold0[i] = 0;
                hold1[i] = 0;
            end
        end else begin
            rdy_exp = (k >= RDY);
            chk("rdy0", rdy0, int'(rdy_exp));
            chk("rdy1", rdy1, int'(rdy_exp));
            ev = (q.size() > 0) && (q[0].due == cyc);
            if (ev || ov0 || ov1) begin
                chk("out_valid0", ov0, int'(ev));
                chk("out_valid1", ov1, int'(ev));
                if (ev) begin
                    e = q.pop_front();
                    chk("out_addr0", oa0, e.addr);
                    chk("out_addr1", oa1, e.addr);
                    chk("out_data_nf0", od0, e.e0);
                    chk("out_data_nf32", od1, e.e1);
                end
            end
            if (in_valid && rdy_exp) begin
                lp0 = ref_sub(ref_log(int'(in_data)), 0);
                lp1 = ref_sub(ref_log(int'(in_data)), 32);
                r0 = lp0;
                r1 = lp1;
                if (HOLD && (int'(in_addr) < NB)) begin
                    r0 = imax(lp0, ref_sub(hold0[in_addr], 2));
                    r1 = imax(lp1, ref_sub(hold1[in_addr], 2));
                end
                if (has_exp) begin
                    r0 = exp0;
                    r1 = exp1;
                end
                if (HOLD && (int'(in_addr) < NB)) begin
                    hold0[in_addr] = r0;
                    hold1[in_addr] = r1;
                end
                q.push_back('{due: cyc + 3, addr: int'(in_addr), e0: r0, e1: r1});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic drive(int a, int d);
        in_valid = 1'b1;
        in_addr  = 9'(a);
        in_data  = 16'(d);
        has_exp  = 1'b0;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drive_x(int a, int d, int e0, int e1);
        in_valid = 1'b1;
        in_addr  = 9'(a);
        in_data  = 16'(d);
        has_exp  = 1'b1;
        exp0     = e0;
        exp1     = e1;
        tick();
        in_valid = 1'b0;
        has_exp  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, d, sel;
        tbl[0] = '{16'h0000, 8'h00, 8'h00};
        tbl[1] = '{16'h0005, 8'h24, 8'h04};
        tbl[2] = '{16'h0300, 8'h98, 8'h78};
        tbl[3] = '{16'h8000, 8'hF0, 8'hD0};
        tbl[4] = '{16'hFFFF, 8'hFF, 8'hDF};
        tbl[5] = '{16'h0001, 8'h00, 8'h00};
        tbl[6] = '{16'h0010, 8'h40, 8'h20};
        tbl[7] = '{16'h0002, 8'h10, 8'h00};

        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        // A write offered during the clear sweep must vanish without trace.
        idle(4);
        drive(3, 16'hFFFF);
        idle(RDY);

        for (int i = 0; i < 8; i++)
            drive_x(100 + i, int'(tbl[i].data), int'(tbl[i].e0), int'(tbl[i].e1));
        idle(5);

        // Spaced decay on bin 7, neighbour bin 8 untouched.
        drive_x(7, 16'hFFFF, 8'hFF, 8'hDF);
        idle(9);
        for (int j = 1; j <= 3; j++) begin
            drive_x(7, 0, HOLD ? 8'hFF - 2 * j : 0, HOLD ? 8'hDF - 2 * j : 0);
            idle(9);
        end
        drive_x(8, 0, 0, 0);
        idle(5);

        // Same decay back-to-back and with a one-cycle gap.
        drive_x(5, 16'hFFFF, 8'hFF, 8'hDF);
        drive_x(5, 0, HOLD ? 8'hFD : 0, HOLD ? 8'hDD : 0);
        drive_x(5, 0, HOLD ? 8'hFB : 0, HOLD ? 8'hDB : 0);
        idle(1);
        drive_x(5, 0, HOLD ? 8'hF9 : 0, HOLD ? 8'hD9 : 0);
        idle(6);

        // Reset one cycle after an accepted input: nothing emerges, hold is cleared.
        drive_x(7, 16'hFFFF, 8'hFF, 8'hDF);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(RDY);
        drive_x(7, 0, 0, 0);
        idle(5);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 5)      a = int'($urandom_range(0, 3));
                else if (sel < 8) a = int'($urandom_range(0, NB - 1));
                else              a = int'($urandom_range(NB, 511));
                d = int'(16'($urandom) >> $urandom_range(0, 16));
                drive(a, d);
            end else begin
                tick();
            end
        end
        idle(10);
        chk("drain_pending", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
